pipe_divider: RTL

//  Parametrised, fully pipelined integer divider with valid/ready handshake on both sides.

---
 rtl/pipe_divider_if.sv | 32 +++
 rtl/pipe_divider.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipe_divider_if.sv
// Request/response bundle of pipe_divider. The slave modport is the divider side,
// the master modport is the producer/consumer side.
interface pipe_divider_if #(
  parameter int DATA_LEN = 32,
  parameter int TAG_LEN  = 8
);
  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // in_ready depends only on the output side, never on in_valid. A pending
  // out_* beat keeps all of its fields stable until out_ready is seen.
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_a;
  logic [DATA_LEN-1:0] in_b;
  logic [TAG_LEN-1:0]  in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_quot;
  logic [DATA_LEN-1:0] out_rem;
  logic [TAG_LEN-1:0]  out_tag;
  logic                out_div0;
  logic                busy;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_tag, out_div0, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_tag, out_div0, busy
  );
endinterface

// File: rtl/pipe_divider.sv
// Fully pipelined restoring divider, DATA_LEN/PIPELINE_STAGE quotient bits per stage.
// Define PIPE_DIV_SIGNED_EN for two's-complement operands (magnitude divide + sign fix-up).
module pipe_divider #(
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 8,
  parameter int TAG_LEN        = 8
) (
  input  logic           clk,
  input  logic           reset,
  pipe_divider_if.slave  io
);
  localparam int P   = PIPELINE_STAGE;
  localparam int BPS = DATA_LEN / PIPELINE_STAGE;

  logic [P-1:0]        vld_q;
  logic [P-1:0]        div0_q;
  logic [DATA_LEN-1:0] rem_q  [P];
  logic [DATA_LEN-1:0] quot_q [P];
  logic [DATA_LEN-1:0] dvs_q  [P];
  logic [TAG_LEN-1:0]  tag_q  [P];
  logic [DATA_LEN-1:0] rem_d  [P];
  logic [DATA_LEN-1:0] quot_d [P];

  logic                out_valid_q;
  logic [DATA_LEN-1:0] out_quot_q;
  logic [DATA_LEN-1:0] out_rem_q;
  logic [TAG_LEN-1:0]  out_tag_q;
  logic                out_div0_q;

  logic                adv;
  logic                b_zero;
  logic [DATA_LEN-1:0] a_mag;
  logic [DATA_LEN-1:0] b_mag;
  logic [DATA_LEN-1:0] quot_fin;
  logic [DATA_LEN-1:0] rem_fin;

  // The whole pipeline, bubbles included, moves as one; a stalled output freezes everything.
  assign adv         = !out_valid_q || io.out_ready;
  assign io.in_ready = adv;
  assign io.busy     = (|vld_q) || out_valid_q;
  assign b_zero      = (io.in_b == '0);

  // BPS restoring steps; quot starts as the dividend and is shifted out MSB first.
  function automatic logic [2*DATA_LEN-1:0] div_steps(
    input logic [DATA_LEN-1:0] rem,
    input logic [DATA_LEN-1:0] quot,
    input logic [DATA_LEN-1:0] dvs
  );
    logic [DATA_LEN:0]   sh;
    logic [DATA_LEN-1:0] r;
    logic [DATA_LEN-1:0] q;
    r = rem;
    q = quot;
    for (int i = 0; i < BPS; i++) begin
      sh = {r, q[DATA_LEN-1]};
      q  = {q[DATA_LEN-2:0], 1'b0};
      if (sh >= {1'b0, dvs}) begin
        sh   = sh - {1'b0, dvs};
        q[0] = 1'b1;
      end
      r = sh[DATA_LEN-1:0];
    end
    return {r, q};
  endfunction

`ifdef PIPE_DIV_SIGNED_EN
  logic [P-1:0] negq_q;
  logic [P-1:0] negr_q;
  logic         a_neg;
  logic         b_neg;

  assign a_neg = io.in_a[DATA_LEN-1];
  assign b_neg = io.in_b[DATA_LEN-1];
  assign a_mag = a_neg ? -io.in_a : io.in_a;
  assign b_mag = b_neg ? -io.in_b : io.in_b;

  // Truncating division: quotient negative when signs differ, remainder follows the dividend.
  assign quot_fin = div0_q[P-1] ? '1 : (negq_q[P-1] ? -quot_q[P-1] : quot_q[P-1]);
  assign rem_fin  = negr_q[P-1] ? -rem_q[P-1] : rem_q[P-1];

  always_ff @(posedge clk) begin
    if (adv) begin
      negq_q[0] <= a_neg ^ b_neg;
      negr_q[0] <= a_neg;
      for (int s = 1; s < P; s++) begin
        negq_q[s] <= negq_q[s-1];
        negr_q[s] <= negr_q[s-1];
      end
    end
  end
`else
  assign a_mag = io.in_a;
  assign b_mag = io.in_b;
  // With a zero divisor every step subtracts nothing, so the remainder already equals a.
  assign quot_fin = div0_q[P-1] ? '1 : quot_q[P-1];
  assign rem_fin  = rem_q[P-1];
`endif

  always_comb begin
    {rem_d[0], quot_d[0]} = div_steps('0, a_mag, b_mag);
    for (int s = 1; s < P; s++) begin
      {rem_d[s], quot_d[s]} = div_steps(rem_q[s-1], quot_q[s-1], dvs_q[s-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_tag_q   <= '0;
      out_div0_q  <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= io.in_valid;
      for (int s = 1; s < P; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      out_valid_q <= vld_q[P-1];
      out_quot_q  <= quot_fin;
      out_rem_q   <= rem_fin;
      out_tag_q   <= tag_q[P-1];
      out_div0_q  <= div0_q[P-1];
    end
  end

  // Payload needs no reset: it is only observed through the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      dvs_q[0]  <= b_mag;
      tag_q[0]  <= io.in_tag;
      div0_q[0] <= b_zero;
      for (int s = 0; s < P; s++) begin
        rem_q[s]  <= rem_d[s];
        quot_q[s] <= quot_d[s];
      end
      for (int s = 1; s < P; s++) begin
        dvs_q[s]  <= dvs_q[s-1];
        tag_q[s]  <= tag_q[s-1];
        div0_q[s] <= div0_q[s-1];
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_quot  = out_quot_q;
  assign io.out_rem   = out_rem_q;
  assign io.out_tag   = out_tag_q;
  assign io.out_div0  = out_div0_q;
endmodule
